tx_arbiter: RTL

Shares one `acia_tx` serial transmitter between up to NREQ byte-stream requesters, such as diagnostic dumpers and command responders. It arbitrates round-robin and holds the grant for a whole message, so lines from different sources never interleave on the wire. The block sits between the requesters and `acia_tx`: it drives `tx_dat`/`tx_start` and consumes `tx_busy`.

---
 rtl/tx_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter -- shares one acia_tx serial transmitter between NREQ byte-stream
// requesters. Arbitration is round-robin and the grant is held for a whole
// message (until a byte flagged req_last has been sent), so messages from
// different sources never interleave on the wire. A granted requester that
// stops presenting bytes loses the grant after LOCK_TO idle cycles.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   req_dat       byte from requester i on bits [8i+7:8i]
//   req_valid     requester i presents a byte
//   req_last      presented byte ends requester i's message (qualified by req_valid)
//   req_ready     accept strobe, only ever to the granted requester
//   grant         one-hot owner of the transmitter, zero when unowned
//   lock_timeout  one-cycle pulse when a grant is revoked by timeout
//   tx_dat        byte to acia_tx, stable from tx_start until the next capture
//   tx_start      one-cycle start strobe to acia_tx
//   tx_busy       acia_tx busy flag
module tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int LOCK_TO = 480000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8*NREQ-1:0] req_dat,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              lock_timeout,
    output logic [7:0]        tx_dat,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_TO + 1);
    // Count value seen in the last idle ACCEPT cycle before revocation
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TO - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCEPT  = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [NREQ-1:0] grant_r;
    logic [PW-1:0]   owner_r;
    logic [PW-1:0]   rr_ptr_r;
    logic [PW-1:0]   rr_next_s;
    logic [PW-1:0]   win_idx_s;
    logic [CW-1:0]   to_cnt_r;
    logic [7:0]      tx_dat_r;
    logic            last_r;
    logic            tx_start_r;
    logic            lock_timeout_r;
    logic [7:0]      own_dat_s;
    logic            own_valid_s;
    logic            own_last_s;
    logic            any_valid_s;
    logic            to_hit_s;
    logic [NREQ-1:0] req_ready_s;
    logic            accept_s;
    logic            timeout_s;
    logic            release_s;

    // First requester with req_valid set, searching upward from ptr with wrap
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx_p;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            idx_p = PW'(idx);
            if (!found && valid[idx_p]) begin
                found = 1'b1;
                pick  = idx_p;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Owner's byte, selected through the one-hot grant
    always_comb begin
        own_dat_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_r[i]) begin
                own_dat_s = own_dat_s | req_dat[8*i +: 8];
            end else begin
                own_dat_s = own_dat_s;
            end
        end
    end

    assign own_valid_s = |(req_valid & grant_r);
    assign own_last_s  = |(req_last & grant_r);
    assign any_valid_s = |req_valid;
    assign win_idx_s   = rr_pick(req_valid, rr_ptr_r);
    assign to_hit_s    = (to_cnt_r == TO_LAST);
    assign rr_next_s   = (owner_r == PW'(NREQ - 1)) ? {PW{1'b0}} : owner_r + PW'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_next_s = ST_ACCEPT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (own_valid_s) begin
                    state_next_s = ST_START;
                end else if (to_hit_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACCEPT;
                end
            end
            ST_START: begin
                state_next_s = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_next_s = ST_WAIT_LO;
                end else begin
                    state_next_s = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (tx_busy) begin
                    state_next_s = ST_WAIT_LO;
                end else if (last_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACCEPT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: the accept strobe answers the owner's req_valid in the same cycle
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        accept_s    = 1'b0;
        timeout_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_ACCEPT: begin
                req_ready_s = req_valid & grant_r;
                accept_s    = own_valid_s;
                timeout_s   = !own_valid_s && to_hit_s;
                release_s   = !own_valid_s && to_hit_s;
            end
            ST_WAIT_LO: begin
                release_s = !tx_busy && last_r;
            end
            default: begin
                req_ready_s = {NREQ{1'b0}};
            end
        endcase
    end

    // Grant, owner index and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_r  <= {NREQ{1'b0}};
            owner_r  <= {PW{1'b0}};
            rr_ptr_r <= {PW{1'b0}};
        end else if ((state_r == ST_IDLE) && any_valid_s) begin
            grant_r  <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
            owner_r  <= win_idx_s;
            rr_ptr_r <= rr_ptr_r;
        end else if (release_s) begin
            grant_r  <= {NREQ{1'b0}};
            owner_r  <= owner_r;
            rr_ptr_r <= rr_next_s;
        end else begin
            grant_r  <= grant_r;
            owner_r  <= owner_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Captured byte and its end-of-message flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_dat_r <= 8'h00;
            last_r   <= 1'b0;
        end else if (accept_s) begin
            tx_dat_r <= own_dat_s;
            last_r   <= own_last_s;
        end else begin
            tx_dat_r <= tx_dat_r;
            last_r   <= last_r;
        end
    end

    // Lock timeout counter: advances only on idle ACCEPT cycles, zero everywhere else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= {CW{1'b0}};
        end else if ((state_r == ST_ACCEPT) && !own_valid_s && !to_hit_s) begin
            to_cnt_r <= to_cnt_r + CW'(1);
        end else begin
            to_cnt_r <= {CW{1'b0}};
        end
    end

    // Registered strobes toward acia_tx and the requesters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_start_r     <= 1'b0;
            lock_timeout_r <= 1'b0;
        end else begin
            tx_start_r     <= (state_next_s == ST_START);
            lock_timeout_r <= timeout_s;
        end
    end

    assign req_ready    = req_ready_s;
    assign grant        = grant_r;
    assign lock_timeout = lock_timeout_r;
    assign tx_dat       = tx_dat_r;
    assign tx_start     = tx_start_r;

endmodule
